// File: rtl/hazard_fwd_scoreboard_if.sv
// Hazard/forwarding controller bus: ID-stage instruction fields in, freeze/forward selects and
// stall counter out. The master side drives ID fields; the slave side is the controller.
interface hazard_fwd_scoreboard_if #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = $clog2(STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic              id_src1_en;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic              flush;
  logic              freeze;
  logic [SEL_W-1:0]  sel_src_1;
  logic [SEL_W-1:0]  sel_src_2;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_src1, id_src1_en, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    output flush,
    input  freeze, sel_src_1, sel_src_2, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src1_en, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
    input  flush,
    output freeze, sel_src_1, sel_src_2, stall_count
  );
endinterface

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard detection and forwarding controller. Tracks every issued instruction from EX to WB
// (entry 0 = EX, entry STAGES-1 = WB), freezes ID on unresolvable dependences, selects EX
// operand sources and counts stall cycles (saturating).
// Build option: define FORWARD_EN to enable forwarding; without it the selects are tied to 0
// and any in-flight producer of a used source (WB included) stalls ID.
module hazard_fwd_scoreboard #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  hazard_fwd_scoreboard_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(STAGES);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic [REG_AW-1:0] dest;
  } prod_t;

  prod_t            e_q [STAGES];
  prod_t            e_d [STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             freeze;
  logic             issue;

`ifdef FORWARD_EN
  logic              load_q [STAGES];
  logic              load_d [STAGES];
  logic [REG_AW-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
  logic              ex_src1_en_q, ex_src1_en_d, ex_src2_en_q, ex_src2_en_d;
`endif

  assign issue = bus.id_valid && !freeze && !bus.flush;

  // Scoreboard shift: ID enters entry 0 (bubble on freeze/flush), older entries advance.
  always_comb begin
    e_d[0] = '{valid: issue, wb_en: bus.id_wb_en, dest: bus.id_dest};
    for (int k = 1; k < int'(STAGES); k++) e_d[k] = e_q[k-1];
`ifdef FORWARD_EN
    load_d[0] = bus.id_mem_r_en;
    for (int k = 1; k < int'(STAGES); k++) load_d[k] = load_q[k-1];
    ex_src1_d    = bus.id_src1;
    ex_src1_en_d = bus.id_src1_en;
    ex_src2_d    = bus.id_src2;
    ex_src2_en_d = bus.id_two_src;
`endif
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) e_q[k] <= '0;
`ifdef FORWARD_EN
      for (int k = 0; k < int'(STAGES); k++) load_q[k] <= 1'b0;
      ex_src1_q    <= '0;
      ex_src1_en_q <= 1'b0;
      ex_src2_q    <= '0;
      ex_src2_en_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < int'(STAGES); k++) e_q[k] <= e_d[k];
`ifdef FORWARD_EN
      for (int k = 0; k < int'(STAGES); k++) load_q[k] <= load_d[k];
      ex_src1_q    <= ex_src1_d;
      ex_src1_en_q <= ex_src1_en_d;
      ex_src2_q    <= ex_src2_d;
      ex_src2_en_q <= ex_src2_en_d;
`endif
    end
  end

  // Hazard: a used ID source matches a producer that cannot yet be forwarded.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      logic blocks;
`ifdef FORWARD_EN
      // Only loads too young to have their data are unforwardable.
      blocks = load_q[k] && (k <= int'(LOAD_RDY) - 2);
`else
      blocks = 1'b1;
`endif
      if (e_q[k].valid && e_q[k].wb_en && blocks) begin
        if ((bus.id_src1_en && (e_q[k].dest == bus.id_src1)) ||
            (bus.id_two_src && (e_q[k].dest == bus.id_src2))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // Flush wins: the ID instruction is discarded anyway. Reset forces outputs low.
  assign freeze = !rst && bus.id_valid && hazard && !bus.flush;

  // Forwarding selects: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    bus.sel_src_1 = '0;
    bus.sel_src_2 = '0;
`ifdef FORWARD_EN
    for (int k = int'(STAGES) - 1; k >= 1; k--) begin
      if (!rst && e_q[0].valid && e_q[k].valid && e_q[k].wb_en) begin
        if (ex_src1_en_q && (e_q[k].dest == ex_src1_q)) bus.sel_src_1 = SEL_W'(k);
        if (ex_src2_en_q && (e_q[k].dest == ex_src2_q)) bus.sel_src_2 = SEL_W'(k);
      end
    end
`endif
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (freeze && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.freeze      = freeze;
  assign bus.stall_count = rst ? '0 : cnt_q;
endmodule
